// File: rtl/rsa_keygen_ctrl.sv
// Sequencer for the RSA exponent datapath: latches L, runs create_e, range-checks E,
// runs the modular inverse for D, and reports done/err with per-unit cycle timeouts.
module rsa_keygen_ctrl #(
  parameter int W       = 64,
  parameter int TIMEOUT = 65535,
  parameter int TW      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_n,
  input  logic [W-1:0] l_in,
  output logic [W-1:0] e_l,
  output logic         e_start_n,
  input  logic         e_ready_n,
  input  logic [W-1:0] e_val,
  output logic [W-1:0] d_e,
  output logic [W-1:0] d_l,
  output logic         d_start_n,
  input  logic         d_ready_n,
  input  logic [W-1:0] d_val,
  output logic [W-1:0] e_out,
  output logic [W-1:0] d_out,
  output logic         done_n,
  output logic         busy,
  output logic [1:0]   err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    E_GO   = 3'd1,
    E_WAIT = 3'd2,
    E_CHK  = 3'd3,
    D_GO   = 3'd4,
    D_WAIT = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam logic [TW:0]  TO_LIM = (TW+1)'(TIMEOUT);
  localparam bit           TO_EN  = (TIMEOUT != 0);
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

  state_t        state_r, state_s;
  logic [TW-1:0] cnt_r, cnt_s, cnt_nxt_s;
  logic [TW:0]   cnt_inc_s;
  logic          first_s, hit_s;
  logic [W-1:0]  l_r, l_s, e_r, e_s, d_r, d_s;
  logic [1:0]    err_r, err_s;
  logic          done_n_r, done_n_s;
  logic          busy_r, busy_s;
  logic          e_start_n_r, e_start_n_s, d_start_n_r, d_start_n_s;

  // Wait-cycle counter helpers; the counter saturates so a disabled timeout never re-arms the first-cycle guard.
  always_comb begin
    cnt_inc_s = {1'b0, cnt_r} + {{TW{1'b0}}, 1'b1};
    cnt_nxt_s = (&cnt_r) ? cnt_r : cnt_inc_s[TW-1:0];
    first_s   = (cnt_r == {TW{1'b0}});
    hit_s     = TO_EN && (cnt_inc_s == TO_LIM);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    l_s      = l_r;
    e_s      = e_r;
    d_s      = d_r;
    err_s    = err_r;
    done_n_s = done_n_r;
    case (state_r)
      IDLE, DONE, ERR: begin
        if (!start_n) begin
          l_s      = l_in;
          err_s    = 2'b00;
          done_n_s = 1'b1;
          state_s  = E_GO;
        end else begin
          state_s  = state_r;
        end
      end
      E_GO: begin
        cnt_s   = {TW{1'b0}};
        state_s = E_WAIT;
      end
      E_WAIT: begin
        cnt_s = cnt_nxt_s;
        // The unit may still show a stale ready in the cycle right after its start strobe.
        if (!first_s && !e_ready_n) begin
          e_s     = e_val;
          state_s = E_CHK;
        end else if (hit_s) begin
          err_s   = 2'b01;
          state_s = ERR;
        end else begin
          state_s = E_WAIT;
        end
      end
      E_CHK: begin
        if ((e_r > ONE_W) && (e_r < l_r)) begin
          state_s = D_GO;
        end else begin
          err_s   = 2'b11;
          state_s = ERR;
        end
      end
      D_GO: begin
        cnt_s   = {TW{1'b0}};
        state_s = D_WAIT;
      end
      D_WAIT: begin
        cnt_s = cnt_nxt_s;
        if (!first_s && !d_ready_n) begin
          d_s      = d_val;
          done_n_s = 1'b0;
          state_s  = DONE;
        end else if (hit_s) begin
          err_s   = 2'b10;
          state_s = ERR;
        end else begin
          state_s = D_WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    e_start_n_s = (state_s != E_GO);
    d_start_n_s = (state_s != D_GO);
    busy_s      = (state_s != IDLE) && (state_s != DONE) && (state_s != ERR);
  end

  // State and output registers; reset also forces the unit start strobes inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {TW{1'b0}};
      l_r         <= {W{1'b0}};
      e_r         <= {W{1'b0}};
      d_r         <= {W{1'b0}};
      err_r       <= 2'b00;
      done_n_r    <= 1'b1;
      busy_r      <= 1'b0;
      e_start_n_r <= 1'b1;
      d_start_n_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      l_r         <= l_s;
      e_r         <= e_s;
      d_r         <= d_s;
      err_r       <= err_s;
      done_n_r    <= done_n_s;
      busy_r      <= busy_s;
      e_start_n_r <= e_start_n_s;
      d_start_n_r <= d_start_n_s;
    end
  end

  assign e_l       = l_r;
  assign d_l       = l_r;
  assign d_e       = e_r;
  assign e_out     = e_r;
  assign d_out     = d_r;
  assign err       = err_r;
  assign done_n    = done_n_r;
  assign busy      = busy_r;
  assign e_start_n = e_start_n_r;
  assign d_start_n = d_start_n_r;

endmodule
